rl_scfifo_dw: RTL and testbench

RL_SCFIFO_DW -- requirements
Module: rl_scfifo_dw

---
 rtl/rl_scfifo_dw_if.sv | 37 +++
 rtl/rl_scfifo_dw.sv | 130 +++++++++++++
 tb/tb_rl_scfifo_dw.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rl_scfifo_dw_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rl_scfifo_dw_if                                               |
// | Desc     : Handshake, data and status bundle for rl_scfifo_dw.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface rl_scfifo_dw_if #(
  parameter int DEPTH        = 16,
  parameter int WR_DATA_SIZE = 32,
  parameter int RD_DATA_SIZE = 32
);
  localparam int c_UW = $clog2(DEPTH) + 1;

  logic                    clr_i;
  logic [WR_DATA_SIZE-1:0] d_i;
  logic                    wrena_i;
  logic                    rdena_i;
  logic [RD_DATA_SIZE-1:0] q_o;
  logic                    empty_o;
  logic                    full_o;
  logic                    almost_empty_o;
  logic                    almost_full_o;
  logic                    ovf_o;
  logic                    unf_o;
  logic [c_UW-1:0]         usedw_o;

  modport master (
    output clr_i, d_i, wrena_i, rdena_i,
    input  q_o, empty_o, full_o, almost_empty_o, almost_full_o, ovf_o, unf_o, usedw_o
  );

  modport slave (
    input  clr_i, d_i, wrena_i, rdena_i,
    output q_o, empty_o, full_o, almost_empty_o, almost_full_o, ovf_o, unf_o, usedw_o
  );
endinterface
`default_nettype wire

// File: rtl/rl_scfifo_dw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rl_scfifo_dw                                                  |
// | Desc     : Single-clock show-ahead FIFO with independent write/read      |
// |            widths; storage and fill level are kept in narrow units.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rl_scfifo_dw #(
  parameter int DEPTH        = 16,
  parameter int WR_DATA_SIZE = 32,
  parameter int RD_DATA_SIZE = 32,
  parameter int AF_LEVEL     = DEPTH - 1,
  parameter int AE_LEVEL     = 1,
  parameter     TECHNOLOGY   = "GENERIC"
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  rl_scfifo_dw_if.slave fifo
);

  localparam int c_NW    = (WR_DATA_SIZE < RD_DATA_SIZE) ? WR_DATA_SIZE : RD_DATA_SIZE;
  localparam int c_MAXW  = (WR_DATA_SIZE < RD_DATA_SIZE) ? RD_DATA_SIZE : WR_DATA_SIZE;
  localparam int c_RATIO = c_MAXW / c_NW;
  localparam int c_WU    = WR_DATA_SIZE / c_NW;
  localparam int c_RU    = RD_DATA_SIZE / c_NW;
  localparam int c_AW    = $clog2(DEPTH);
  localparam int c_UW    = c_AW + 1;

  localparam logic [c_AW-1:0] c_WU_P    = c_AW'(c_WU);
  localparam logic [c_AW-1:0] c_RU_P    = c_AW'(c_RU);
  localparam logic [c_UW-1:0] c_WU_U    = c_UW'(c_WU);
  localparam logic [c_UW-1:0] c_RU_U    = c_UW'(c_RU);
  localparam logic [c_UW-1:0] c_FULL_TH = c_UW'(DEPTH - c_WU);
  localparam logic [c_UW-1:0] c_AF_TH   = c_UW'(AF_LEVEL);
  localparam logic [c_UW-1:0] c_AE_TH   = c_UW'(AE_LEVEL);
  localparam logic            c_AF_RST  = (AF_LEVEL == 0);

  if ((DEPTH & (DEPTH - 1)) != 0 || (c_MAXW % c_NW) != 0 ||
      (c_RATIO & (c_RATIO - 1)) != 0 || (DEPTH % c_RATIO) != 0) begin : g_bad_params
    $error("rl_scfifo_dw: DEPTH/width combination is not supported");
  end

  logic [c_NW-1:0]         r_mem [DEPTH];
  logic [c_AW-1:0]         r_wr_ptr;
  logic [c_AW-1:0]         r_rd_ptr;
  logic [c_UW-1:0]         r_usedw;
  logic                    r_empty;
  logic                    r_full;
  logic                    r_aempty;
  logic                    r_afull;
  logic                    r_ovf;
  logic                    r_unf;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [c_UW-1:0]         w_usedw_nxt;
  logic [RD_DATA_SIZE-1:0] w_q;

  // Acceptance looks only at the registered flags, so a same-cycle read
  // never frees room for a write and a same-cycle write never feeds a read.
  assign w_wr_acc    = fifo.wrena_i & ~r_full;
  assign w_rd_acc    = fifo.rdena_i & ~r_empty;
  assign w_usedw_nxt = r_usedw + (w_wr_acc ? c_WU_U : '0) - (w_rd_acc ? c_RU_U : '0);

  if (TECHNOLOGY == "GENERIC") begin : g_mem_generic
    always_ff @(posedge clk_i) begin
      if (w_wr_acc && !fifo.clr_i) begin
        for (int i = 0; i < c_WU; i++) begin
          r_mem[r_wr_ptr + c_AW'(i)] <= fifo.d_i[i*c_NW +: c_NW];
        end
      end
    end
  end else begin : g_mem_unsupported
    $error("rl_scfifo_dw: no storage mapping for the selected TECHNOLOGY");
  end

  // Show-ahead: the oldest RU units are always presented, lowest unit first.
  for (genvar g = 0; g < c_RU; g++) begin : g_rd_unit
    localparam logic [c_AW-1:0] c_OFF = c_AW'(g);
    assign w_q[g*c_NW +: c_NW] = r_mem[r_rd_ptr + c_OFF];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= c_AF_RST;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (fifo.clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= c_AF_RST;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_WU_P;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_RU_P;
      end
      r_usedw  <= w_usedw_nxt;
      r_full   <= (w_usedw_nxt > c_FULL_TH);
      r_empty  <= (w_usedw_nxt < c_RU_U);
      r_afull  <= (w_usedw_nxt >= c_AF_TH);
      r_aempty <= (w_usedw_nxt <= c_AE_TH);
      r_ovf    <= r_ovf | (fifo.wrena_i & r_full);
      r_unf    <= r_unf | (fifo.rdena_i & r_empty);
    end
  end

  assign fifo.q_o            = w_q;
  assign fifo.usedw_o        = r_usedw;
  assign fifo.empty_o        = r_empty;
  assign fifo.full_o         = r_full;
  assign fifo.almost_empty_o = r_aempty;
  assign fifo.almost_full_o  = r_afull;
  assign fifo.ovf_o          = r_ovf;
  assign fifo.unf_o          = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_rl_scfifo_dw.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rl_scfifo_dw                                               |
// | Desc     : Three width configurations of rl_scfifo_dw against a          |
// |            list-of-units reference model.                                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_rl_scfifo_dw;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clr;
  logic [2:0]  wr;
  logic [2:0]  rd;
  logic [31:0] d;

  always #5 clk_i = ~clk_i;

  // Instance 0: 8 -> 32, instance 1: 32 -> 8, instance 2: 32 -> 32.
  rl_scfifo_dw_if #(.DEPTH(16), .WR_DATA_SIZE(8),  .RD_DATA_SIZE(32)) if_a ();
  rl_scfifo_dw_if #(.DEPTH(16), .WR_DATA_SIZE(32), .RD_DATA_SIZE(8))  if_b ();
  rl_scfifo_dw_if #(.DEPTH(16), .WR_DATA_SIZE(32), .RD_DATA_SIZE(32)) if_c ();

  rl_scfifo_dw #(.DEPTH(16), .WR_DATA_SIZE(8), .RD_DATA_SIZE(32))
    u_dut_a (.clk_i(clk_i), .rst_ni(rst_ni), .fifo(if_a));
  rl_scfifo_dw #(.DEPTH(16), .WR_DATA_SIZE(32), .RD_DATA_SIZE(8))
    u_dut_b (.clk_i(clk_i), .rst_ni(rst_ni), .fifo(if_b));
  rl_scfifo_dw #(.DEPTH(16), .WR_DATA_SIZE(32), .RD_DATA_SIZE(32), .AF_LEVEL(15))
    u_dut_c (.clk_i(clk_i), .rst_ni(rst_ni), .fifo(if_c));

  assign if_a.clr_i = clr;  assign if_a.d_i = d[7:0]; assign if_a.wrena_i = wr[0]; assign if_a.rdena_i = rd[0];
  assign if_b.clr_i = clr;  assign if_b.d_i = d;      assign if_b.wrena_i = wr[1]; assign if_b.rdena_i = rd[1];
  assign if_c.clr_i = clr;  assign if_c.d_i = d;      assign if_c.wrena_i = wr[2]; assign if_c.rdena_i = rd[2];

  logic [31:0] obs_q [3];
  logic [4:0]  obs_u [3];
  logic [5:0]  obs_f [3];  // {empty, full, almost_empty, almost_full, ovf, unf}

  assign obs_q[0] = if_a.q_o;
  assign obs_q[1] = {24'h0, if_b.q_o};
  assign obs_q[2] = if_c.q_o;
  assign obs_u[0] = if_a.usedw_o;
  assign obs_u[1] = if_b.usedw_o;
  assign obs_u[2] = if_c.usedw_o;
  assign obs_f[0] = {if_a.empty_o, if_a.full_o, if_a.almost_empty_o, if_a.almost_full_o, if_a.ovf_o, if_a.unf_o};
  assign obs_f[1] = {if_b.empty_o, if_b.full_o, if_b.almost_empty_o, if_b.almost_full_o, if_b.ovf_o, if_b.unf_o};
  assign obs_f[2] = {if_c.empty_o, if_c.full_o, if_c.almost_empty_o, if_c.almost_full_o, if_c.ovf_o, if_c.unf_o};

  int    wu_k [3] = '{1, 4, 1};
  int    ru_k [3] = '{4, 1, 1};
  int    nw_k [3] = '{8, 8, 32};
  int    af_k [3] = '{15, 15, 15};
  string nm   [3] = '{"A", "B", "C"};

  // Reference model: an ordered list of narrow units per instance.
  logic [31:0] mm [3][32];
  int          mc [3];
  bit          m_ovf [3];
  bit          m_unf [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] unit_mask(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  task automatic model_clear(input int k);
    mc[k]    = 0;
    m_ovf[k] = 1'b0;
    m_unf[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    bit full, empty;
    full  = mc[k] > 16 - wu_k[k];
    empty = mc[k] < ru_k[k];
    if (clr) begin
      model_clear(k);
    end else begin
      if (wr[k] && full)  m_ovf[k] = 1'b1;
      if (rd[k] && empty) m_unf[k] = 1'b1;
      if (rd[k] && !empty) begin
        for (int i = 0; i < mc[k] - ru_k[k]; i++) mm[k][i] = mm[k][i + ru_k[k]];
        mc[k] -= ru_k[k];
      end
      if (wr[k] && !full) begin
        for (int i = 0; i < wu_k[k]; i++) begin
          mm[k][mc[k]] = (d >> (i * nw_k[k])) & unit_mask(nw_k[k]);
          mc[k]++;
        end
      end
    end
  endtask

  task automatic check_all(input int k);
    logic [31:0] exp_q;
    int          cnt;
    cnt = mc[k];
    chk_val({nm[k], ".usedw"},  32'(obs_u[k]),    32'(cnt));
    chk_val({nm[k], ".empty"},  32'(obs_f[k][5]), 32'(cnt < ru_k[k]));
    chk_val({nm[k], ".full"},   32'(obs_f[k][4]), 32'(cnt > 16 - wu_k[k]));
    chk_val({nm[k], ".aempty"}, 32'(obs_f[k][3]), 32'(cnt <= 1));
    chk_val({nm[k], ".afull"},  32'(obs_f[k][2]), 32'(cnt >= af_k[k]));
    chk_val({nm[k], ".ovf"},    32'(obs_f[k][1]), 32'(m_ovf[k]));
    chk_val({nm[k], ".unf"},    32'(obs_f[k][0]), 32'(m_unf[k]));
    if (cnt >= ru_k[k]) begin
      exp_q = '0;
      for (int i = 0; i < ru_k[k]; i++) exp_q = exp_q | (mm[k][i] << (i * nw_k[k]));
      chk_val({nm[k], ".q"}, obs_q[k], exp_q);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there.
  task automatic cycle();
    @(posedge clk_i);
    for (int k = 0; k < 3; k++) begin
      if (!rst_ni) model_clear(k);
      else         model_step(k);
    end
    #1;
    for (int k = 0; k < 3; k++) check_all(k);
  endtask

  task automatic clear_all();
    wr  = '0;
    rd  = '0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    int          pw, pr;

    rst_ni = 1'b0;
    clr    = 1'b0;
    wr     = '0;
    rd     = '0;
    d      = '0;
    for (int k = 0; k < 3; k++) model_clear(k);
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk_val({nm[k], ".rst_usedw"},  32'(obs_u[k]),    32'd0);
      chk_val({nm[k], ".rst_empty"},  32'(obs_f[k][5]), 32'd1);
      chk_val({nm[k], ".rst_aempty"}, 32'(obs_f[k][3]), 32'd1);
      chk_val({nm[k], ".rst_afull"},  32'(obs_f[k][2]), 32'd0);
    end
    cycle();
    rst_ni = 1'b1;

    // 8-bit writes assembled into one 32-bit read word.
    wr[0] = 1'b1;
    d = 32'h11; cycle();
    d = 32'h22; cycle();
    d = 32'h33; cycle();
    d = 32'h44; cycle();
    wr[0] = 1'b0;
    chk_val("narrow_wr.usedw", 32'(obs_u[0]),    32'd4);
    chk_val("narrow_wr.empty", 32'(obs_f[0][5]), 32'd0);
    chk_val("narrow_wr.q",     obs_q[0],          32'h4433_2211);
    rd[0] = 1'b1; cycle(); rd[0] = 1'b0;
    chk_val("narrow_wr.usedw_after_rd", 32'(obs_u[0]),    32'd0);
    chk_val("narrow_wr.empty_after_rd", 32'(obs_f[0][5]), 32'd1);

    // One 32-bit write split into four 8-bit reads, LSB first.
    word  = 32'hAABB_CCDD;
    wr[1] = 1'b1; d = word; cycle(); wr[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_val("narrow_rd.q", obs_q[1], (word >> (8 * i)) & 32'hFF);
      rd[1] = 1'b1; cycle(); rd[1] = 1'b0;
    end
    chk_val("narrow_rd.empty", 32'(obs_f[1][5]), 32'd1);

    // Fill equal-width instance to full, then overflow.
    wr[2] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      d = 32'(100 + i);
      cycle();
    end
    chk_val("fill15.afull", 32'(obs_f[2][2]), 32'd1);
    chk_val("fill15.full",  32'(obs_f[2][4]), 32'd0);
    d = 32'd116; cycle();
    chk_val("fill16.full",  32'(obs_f[2][4]), 32'd1);
    chk_val("fill16.usedw", 32'(obs_u[2]),    32'd16);
    d = 32'd117; cycle();
    chk_val("ovf.flag",  32'(obs_f[2][1]), 32'd1);
    chk_val("ovf.usedw", 32'(obs_u[2]),    32'd16);
    chk_val("ovf.q",     obs_q[2],          32'd101);
    clear_all();

    // Read and write together on an empty FIFO.
    wr[2] = 1'b1; rd[2] = 1'b1; d = 32'h5A5A_1234; cycle();
    wr[2] = 1'b0; rd[2] = 1'b0;
    chk_val("rdwr_empty.unf",   32'(obs_f[2][0]), 32'd1);
    chk_val("rdwr_empty.usedw", 32'(obs_u[2]),    32'd1);
    chk_val("rdwr_empty.q",     obs_q[2],          32'h5A5A_1234);
    clear_all();

    // Narrow-write simultaneous read/write, then clear dominating a write.
    wr[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d = 32'(i);
      cycle();
    end
    chk_val("simul.usedw_pre", 32'(obs_u[0]), 32'd4);
    rd[0] = 1'b1; d = 32'd5; cycle(); rd[0] = 1'b0;
    chk_val("simul.usedw", 32'(obs_u[0]), 32'd1);
    clr = 1'b1; d = 32'd6; cycle(); clr = 1'b0; wr[0] = 1'b0;
    chk_val("clr_wr.usedw",  32'(obs_u[0]),    32'd0);
    chk_val("clr_wr.empty",  32'(obs_f[0][5]), 32'd1);
    chk_val("clr_wr.aempty", 32'(obs_f[0][3]), 32'd1);
    chk_val("clr_wr.full",   32'(obs_f[0][4]), 32'd0);
    chk_val("clr_wr.errs",   32'(obs_f[0][1:0]), 32'd0);

    // Randomised traffic in epochs of differing read/write pressure.
    for (int ep = 0; ep < 12; ep++) begin
      pw = $urandom_range(90, 15);
      pr = $urandom_range(90, 15);
      for (int c = 0; c < 80; c++) begin
        for (int k = 0; k < 3; k++) begin
          wr[k] = ($urandom_range(99) < pw);
          rd[k] = ($urandom_range(99) < pr);
        end
        d   = $urandom();
        clr = ($urandom_range(63) == 0);
        if (ep == 6 && c == 40) begin
          rst_ni = 1'b0;
          #1;
          for (int k = 0; k < 3; k++) begin
            model_clear(k);
            chk_val({nm[k], ".arst_usedw"}, 32'(obs_u[k]),      32'd0);
            chk_val({nm[k], ".arst_empty"}, 32'(obs_f[k][5]),   32'd1);
            chk_val({nm[k], ".arst_full"},  32'(obs_f[k][4]),   32'd0);
            chk_val({nm[k], ".arst_errs"},  32'(obs_f[k][1:0]), 32'd0);
          end
          cycle();
          rst_ni = 1'b1;
        end
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
